// File: rtl/pri_enc_scanner.sv
// pri_enc_scanner: accepts an N-bit request vector over a valid/ready handshake.
// It then emits the index of every set bit, one index per output beat, in
// priority order. An all-zero vector is flagged with a one-cycle zero_err pulse.
module pri_enc_scanner #(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_err,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   pend_reg, pend_next;
  logic           zero_err_reg, zero_err_next;

  logic [W-1:0]   enc_idx;
  logic           enc_single;
  logic [N-1:0]   clr_mask;

  // Priority-encode the pending set. Each loop iteration overwrites earlier
  // matches, so the scan direction decides which end wins.
  always_comb begin
    enc_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pend_reg[i]) enc_idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend_reg[i]) enc_idx = W'(i);
      end
    end
  end

  // Exactly one pending bit: clearing the lowest set bit leaves nothing.
  assign enc_single = (pend_reg != '0) &&
                      ((pend_reg & (pend_reg - {{(N-1){1'b0}}, 1'b1})) == '0);

  // One-hot mask of the bit being serviced on this beat.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign clr_mask[gi] = (enc_idx == W'(gi));
    end
  endgenerate

  // Handshake and data outputs; everything is gated quiet while in reset.
  always_comb begin
    in_ready  = (state_reg == IDLE) && !rst;
    out_valid = (state_reg == SCAN) && !rst;
    busy      = (state_reg == SCAN);
    zero_err  = zero_err_reg;
    out_idx   = out_valid ? enc_idx : '0;
    out_last  = out_valid ? enc_single : 1'b0;
  end

  // Next-state logic: accept in IDLE, retire one index per beat in SCAN.
  always_comb begin
    state_next    = state_reg;
    pend_next     = pend_reg;
    zero_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_vec != '0) begin
            pend_next  = in_vec;
            state_next = SCAN;
          end else begin
            zero_err_next = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_valid && out_ready) begin
          pend_next = pend_reg & ~clr_mask;
          if (enc_single) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pend_reg     <= '0;
      zero_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      zero_err_reg <= zero_err_next;
    end
  end

endmodule

// File: tb/tb_pri_enc_scanner.sv
// Testbench for pri_enc_scanner: two instances, one per priority direction,
// are driven with identical stimulus and checked against per-vector index lists.
module tb_pri_enc_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       m_in_ready, m_out_valid, m_out_last, m_zero_err, m_busy;
  logic [2:0] m_out_idx;
  logic       l_in_ready, l_out_valid, l_out_last, l_zero_err, l_busy;
  logic [2:0] l_out_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pri_enc_scanner #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_out_idx), .out_last(m_out_last), .zero_err(m_zero_err), .busy(m_busy)
  );

  pri_enc_scanner #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_out_idx), .out_last(l_out_last), .zero_err(l_zero_err), .busy(l_busy)
  );

  // Checks beats of an already-accepted vector until every set bit is emitted.
  // mode 0: out_ready always 1; 1: toggles 1,0,1,0; 2: random.
  task automatic expect_beats(input logic [7:0] vec, input int mode);
    int   qm[$];
    int   ql[$];
    int   cyc;
    logic r;
    for (int i = 7; i >= 0; i--) if (vec[i]) qm.push_back(i);
    for (int i = 0; i < 8; i++)  if (vec[i]) ql.push_back(i);
    cyc = 0;
    while (qm.size() > 0 && cyc < 64) begin
      tests_run++;
      if ({m_out_valid, l_out_valid, m_in_ready, l_in_ready, m_busy, l_busy} !== 6'b110011) begin
        tests_failed++;
        $display("FAIL scan_hs vec=%h: got valid=%b%b ready=%b%b busy=%b%b want 11 00 11",
                 vec, m_out_valid, l_out_valid, m_in_ready, l_in_ready, m_busy, l_busy);
      end
      tests_run++;
      if (m_out_idx !== 3'(qm[0]) || m_out_last !== 1'(qm.size() == 1)) begin
        tests_failed++;
        $display("FAIL msb_beat vec=%h: got idx=%0d last=%b want idx=%0d last=%b",
                 vec, m_out_idx, m_out_last, qm[0], (qm.size() == 1));
      end
      tests_run++;
      if (l_out_idx !== 3'(ql[0]) || l_out_last !== 1'(ql.size() == 1)) begin
        tests_failed++;
        $display("FAIL lsb_beat vec=%h: got idx=%0d last=%b want idx=%0d last=%b",
                 vec, l_out_idx, l_out_last, ql[0], (ql.size() == 1));
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      @(negedge clk);
      if (r) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      cyc++;
    end
    out_ready = 1'b1;
    tests_run++;
    if (qm.size() != 0) begin
      tests_failed++;
      $display("FAIL beat_timeout vec=%h: got %0d beats left want 0", vec, qm.size());
    end
    tests_run++;
    if ({m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_busy, l_busy,
         m_out_idx, l_out_idx, m_out_last, l_out_last} !== {4'b1100, 2'b00, 6'd0, 2'b00}) begin
      tests_failed++;
      $display("FAIL back_idle vec=%h: got ready=%b%b valid=%b%b busy=%b%b idx=%0d/%0d last=%b%b want ready=11 rest 0",
               vec, m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_busy, l_busy,
               m_out_idx, l_out_idx, m_out_last, l_out_last);
    end
  endtask

  // Offers one vector for a single cycle, then checks its whole transaction.
  task automatic run_vec(input logic [7:0] vec, input int mode);
    @(negedge clk);
    tests_run++;
    if ({m_in_ready, l_in_ready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL accept_ready vec=%h: got %b%b want 11", vec, m_in_ready, l_in_ready);
    end
    in_valid = 1'b1;
    in_vec   = vec;
    @(negedge clk);
    in_valid = 1'b0;
    $display("[TB] transaction vec=%h mode=%0d", vec, mode);
    if (vec == 8'h00) begin
      tests_run++;
      if ({m_zero_err, l_zero_err, m_out_valid, l_out_valid, m_in_ready, l_in_ready} !== 6'b110011) begin
        tests_failed++;
        $display("FAIL zero_pulse: got zerr=%b%b valid=%b%b ready=%b%b want 11 00 11",
                 m_zero_err, l_zero_err, m_out_valid, l_out_valid, m_in_ready, l_in_ready);
      end
      @(negedge clk);
      tests_run++;
      if ({m_zero_err, l_zero_err, m_out_valid, l_out_valid} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL zero_clear: got zerr=%b%b valid=%b%b want 0000",
                 m_zero_err, l_zero_err, m_out_valid, l_out_valid);
      end
    end else begin
      expect_beats(vec, mode);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_busy, l_busy, m_zero_err, l_zero_err} !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got ready=%b%b valid=%b%b busy=%b%b zerr=%b%b want all 0",
               m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_busy, l_busy, m_zero_err, l_zero_err);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({m_in_ready, l_in_ready, m_busy, l_busy} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b%b busy=%b%b want 11 00", m_in_ready, l_in_ready, m_busy, l_busy);
    end
  endtask

  task automatic test_basic();
    run_vec(8'h11, 0);
    run_vec(8'h01, 0);
    run_vec(8'h80, 0);
  endtask

  task automatic test_all_stall();
    run_vec(8'hFF, 1);
  endtask

  task automatic test_zero();
    run_vec(8'h00, 0);
  endtask

  // A second vector held valid throughout a scan must wait until IDLE.
  task automatic test_ignore();
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = 8'hC0;
    @(negedge clk);
    in_vec   = 8'h0F;
    $display("[TB] transaction vec=c0 with 0f pending");
    expect_beats(8'hC0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    $display("[TB] transaction vec=0f accepted after idle");
    expect_beats(8'h0F, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = 8'hFF;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    $display("[TB] transaction vec=ff reset after two beats");
    tests_run++;
    if ({m_out_idx, l_out_idx} !== {3'd7, 3'd0}) begin
      tests_failed++;
      $display("FAIL mid_beat0: got idx=%0d/%0d want 7/0", m_out_idx, l_out_idx);
    end
    @(negedge clk);
    tests_run++;
    if ({m_out_idx, l_out_idx} !== {3'd6, 3'd1}) begin
      tests_failed++;
      $display("FAIL mid_beat1: got idx=%0d/%0d want 6/1", m_out_idx, l_out_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({m_out_valid, l_out_valid, m_in_ready, l_in_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_rst_comb: got valid=%b%b ready=%b%b want 0000", m_out_valid, l_out_valid, m_in_ready, l_in_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, l_out_valid, m_busy, l_busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_rst_state: got valid=%b%b busy=%b%b want 0000", m_out_valid, l_out_valid, m_busy, l_busy);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_busy, l_busy} !== 6'b110000) begin
      tests_failed++;
      $display("FAIL mid_rst_release: got ready=%b%b valid=%b%b busy=%b%b want 11 00 00",
               m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_busy, l_busy);
    end
    run_vec(8'h24, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_vec(8'($urandom_range(0, 255)), 2);
    end
  endtask

  task automatic test_back_to_back();
    run_vec(8'hA5, 0);
    run_vec(8'h5A, 0);
    run_vec(8'h00, 0);
    run_vec(8'h3C, 2);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_all_stall();
    test_zero();
    test_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
